alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised successor to the team's 4-bit combinational ALU. It takes WIDTH-bit operands and a 3-bit opcode through a valid/ready handshake. Single-cycle ops register their result in one cycle; MUL runs as a multi-cycle shift-add engine. It outputs a registered result plus zero/carry/overflow/negative flags, and sits between the datapath controller and the writeback stage.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept a new operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
opcode  input  3  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0
carry  output  1  carry/borrow/shift-out/mul-overflow
overflow  output  1  signed overflow (ADD/SUB only)
negative  output  1  result[WIDTH-1]

Behaviour:
- Reset: rst_n low forces state to IDLE immediately, regardless of clk. result, all flags and out_valid are 0. The MUL accumulator and counter are cleared. Any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1.
  - BUSY: MUL in progress, in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept: accept occurs on a rising edge where in_valid && in_ready. a, b and opcode are captured. Input changes at any other time are ignored.
- Opcodes:
  - 000 ADD
  - 001 SUB (a-b)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL a by b[SHW-1:0]
  - 110 SRL a by b[SHW-1:0]
  - 111 MUL (unsigned, low WIDTH bits)
- Non-MUL latency: accept -> DONE on the same edge. out_valid is high the cycle after the accept edge.
- MUL latency: accept -> BUSY. Each BUSY cycle processes one multiplier bit, LSB first, into a 2*WIDTH accumulator. After WIDTH BUSY cycles -> DONE. out_valid rises exactly WIDTH+1 cycles after the accept edge.
- Flags:
  - zero = (result==0).
  - negative = result MSB.
  - ADD: carry = carry-out of bit WIDTH-1.
  - SUB: carry = borrow (a<b unsigned).
  - ADD/SUB overflow: set on two's-complement signed overflow.
  - Overflow is 0 for all other ops.
  - Logic ops: carry=0.
  - SLL: carry = last bit shifted out of MSB. SRL: carry = last bit shifted out of LSB. Shift amount 0 -> carry=0.
  - MUL: carry = |product[2*WIDTH-1:WIDTH].
- Output hold: in DONE with out_ready=0, result and flags are held stable and in_ready=0.
- Output handshake: in DONE with out_ready=1, the result is consumed on that edge.
  - If in_valid is also 1, the new op is accepted on the same edge (back-to-back). Next state is DONE (non-MUL) or BUSY (MUL).
  - Otherwise -> IDLE, out_valid=0.
- Flag lifetime: flags and result only update when a new result enters DONE. They keep their last value in IDLE/BUSY but are qualified by out_valid.
- Reset mid-MUL (or in DONE): returns to IDLE. The result is lost and no out_valid pulse is produced.

Test Plan:
(WIDTH=8)
1. ADD 0xF0+0x20 -> result 0x10, carry=1, overflow=0, zero=0. ADD 0x7F+0x01 -> 0x80, overflow=1, negative=1, carry=0. out_valid one cycle after accept.
2. SUB 0x03-0x03 -> 0x00, zero=1, carry=0. SUB 0x02-0x05 -> 0xFD, carry=1, negative=1. SUB 0x80-0x01 -> 0x7F, overflow=1.
3. SLL 0x81 by 1 -> 0x02, carry=1. SRL 0x81 by 0x09 (amount 1) -> 0x40, carry=1. SLL by 0 -> result unchanged, carry=0. AND/OR/XOR 0xCC,0xAA -> 0x88/0xEE/0x66, carry=0.
4. MUL 0x0C*0x0B -> 0x84, carry=0, out_valid exactly 9 cycles after accept, in_ready=0 throughout BUSY. MUL 0x20*0x10 -> 0x00, carry=1, zero=1.
5. Backpressure and back-to-back:
   - Hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0.
   - Raise out_ready with in_valid=1 carrying ADD -> new result next cycle with no idle gap.
   - Then MUL back-to-back -> BUSY entered directly.
6. Assert rst_n=0 mid-edge during MUL BUSY cycle 4 -> outputs zero immediately (asynchronous), no out_valid afterward. Release reset, issue ADD 0x01+0x01 -> 0x02 normally.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready front end, registered result and flags,
// and a one-bit-per-cycle shift-add multiplier for MUL.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ov;
  } alu_t;

  // Single-cycle operations. Overflow uses a sign-extended (WIDTH+1)-bit sum:
  // the top two bits disagree exactly when the signed result does not fit.
  function automatic alu_t alu_eval(input logic [2:0] op,
                                    input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y);
    alu_t                    r;
    logic [WIDTH:0]          uext;
    logic signed [WIDTH:0]   sext;
    logic [2*WIDTH-1:0]      wide;
    logic [SHW-1:0]          sh;
    r    = '0;
    uext = '0;
    sext = '0;
    wide = '0;
    sh   = y[SHW-1:0];
    case (op)
      OP_ADD: begin
        uext  = {1'b0, x} + {1'b0, y};
        sext  = $signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y});
        r.res = uext[WIDTH-1:0];
        r.cy  = uext[WIDTH];
        r.ov  = sext[WIDTH] ^ sext[WIDTH-1];
      end
      OP_SUB: begin
        uext  = {1'b0, x} - {1'b0, y};
        sext  = $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
        r.res = uext[WIDTH-1:0];
        r.cy  = uext[WIDTH];
        r.ov  = sext[WIDTH] ^ sext[WIDTH-1];
      end
      OP_AND: r.res = x & y;
      OP_OR:  r.res = x | y;
      OP_XOR: r.res = x ^ y;
      OP_SLL: begin
        // The last bit pushed past the MSB lands at position WIDTH.
        wide  = {{WIDTH{1'b0}}, x} << sh;
        r.res = wide[WIDTH-1:0];
        r.cy  = wide[WIDTH];
      end
      OP_SRL: begin
        wide  = {x, {WIDTH{1'b0}}} >> sh;
        r.res = wide[2*WIDTH-1:WIDTH];
        r.cy  = wide[WIDTH-1];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  alu_t               alu_r;

  logic [2*WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [CW-1:0]      cnt_p1;
  logic               mul_last;
  logic [2*WIDTH-1:0] acc_step;

  assign alu_r    = alu_eval(opcode, a, b);
  assign mul_last = (cnt_p1 == CW'(WIDTH));
  assign acc_step = mplier_p1[0] ? (acc_p1 + mcand_p1) : acc_p1;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (opcode == OP_MUL) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (mul_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_nxt = (opcode == OP_MUL) ? BUSY : DONE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // p1: multiplier engine, one multiplier bit per BUSY cycle, LSB first.
  // The extra BUSY cycle with cnt == WIDTH hands the product to the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_p1  <= '0;
      mplier_p1 <= '0;
      acc_p1    <= '0;
      cnt_p1    <= '0;
    end else if (accept && (opcode == OP_MUL)) begin
      mcand_p1  <= {{WIDTH{1'b0}}, a};
      mplier_p1 <= b;
      acc_p1    <= '0;
      cnt_p1    <= '0;
    end else if ((state == BUSY) && !mul_last) begin
      acc_p1    <= acc_step;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      cnt_p1    <= cnt_p1 + CW'(1);
    end
  end

  // p2: result/flag register, written only when a new result enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
    end else if (accept && (opcode != OP_MUL)) begin
      result   <= alu_r.res;
      zero     <= is_zero(alu_r.res);
      carry    <= alu_r.cy;
      overflow <= alu_r.ov;
      negative <= alu_r.res[WIDTH-1];
    end else if ((state == BUSY) && mul_last) begin
      result   <= acc_p1[WIDTH-1:0];
      zero     <= is_zero(acc_p1[WIDTH-1:0]);
      carry    <= |acc_p1[2*WIDTH-1:WIDTH];
      overflow <= 1'b0;
      negative <= acc_p1[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes model predictions with their
// due cycle, a negedge monitor pops and compares whatever the DUT presents.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    int res;
    int z;
    int c;
    int v;
    int n;
    int acc_c;
    int due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry, overflow, negative;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   seen = 0;
  bit   rnd_ready = 0;
  bit   fixed_ready = 1;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .negative(negative)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic exp_t model(input int op, input int x, input int y);
    exp_t e;
    int   full, s, sh;
    e = '{default: 0};
    sh = y % W;
    case (op)
      0: begin
        full = x + y;  e.res = full & MASK;  e.c = (full > MASK) ? 1 : 0;
        s = sgn(x) + sgn(y);
        e.v = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
      end
      1: begin
        full = x - y;  e.res = full & MASK;  e.c = (x < y) ? 1 : 0;
        s = sgn(x) - sgn(y);
        e.v = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
      end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = x ^ y;
      5: begin
        e.res = (x << sh) & MASK;
        e.c = (sh != 0) ? ((x >> (W - sh)) & 1) : 0;
      end
      6: begin
        e.res = x >> sh;
        e.c = (sh != 0) ? ((x >> (sh - 1)) & 1) : 0;
      end
      default: begin
        full = x * y;  e.res = full & MASK;  e.c = ((full >> W) != 0) ? 1 : 0;
      end
    endcase
    e.z = (e.res == 0) ? 1 : 0;
    e.n = (e.res >> (W - 1)) & 1;
    return e;
  endfunction

  task automatic issue(input int op, input int xa, input int xb);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    opcode = 3'(op);
    a = W'(xa);
    b = W'(xb);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
    end else begin
      e = model(op, xa, xb);
      e.acc_c = cyc + 1;
      e.due = cyc + 1 + ((op == 7) ? W + 1 : 0);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode = 3'($urandom);
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        if (!seen) begin
          chk("latency", cyc, q[0].due);
          seen = 1;
        end
        chk("result", int'(result), q[0].res);
        chk("zero", int'(zero), q[0].z);
        chk("carry", int'(carry), q[0].c);
        chk("overflow", int'(overflow), q[0].v);
        chk("negative", int'(negative), q[0].n);
        chk("in_ready_done", int'(in_ready), int'(out_ready));
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end else if (q.size() != 0 && cyc >= q[0].acc_c) begin
      chk("in_ready_busy", int'(in_ready), 0);
      if (cyc > q[0].due) begin
        chk("late_out_valid", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int ops[13];
    int xs[13];
    int ys[13];
    ops = '{0, 0, 1, 1, 1, 5, 6, 5, 2, 3, 4, 7, 7};
    xs  = '{8'hF0, 8'h7F, 8'h03, 8'h02, 8'h80, 8'h81, 8'h81, 8'h5A, 8'hCC, 8'hCC, 8'hCC, 8'h0C, 8'h20};
    ys  = '{8'h20, 8'h01, 8'h03, 8'h05, 8'h01, 8'h01, 8'h09, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'h0B, 8'h10};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({zero, carry, overflow, negative}), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) issue(ops[i], xs[i], ys[i]);
    wait_idle();

    // Backpressure, then back-to-back ADD and MUL.
    fixed_ready = 0;
    repeat (2) @(negedge clk);
    issue(0, 8'h33, 8'h44);
    repeat (6) @(negedge clk);
    fixed_ready = 1;
    issue(0, 8'h55, 8'hAB);
    issue(7, 8'h0F, 8'h11);
    issue(1, 8'h10, 8'h20);
    wait_idle();

    // Asynchronous reset in the middle of a MUL.
    issue(7, 8'h0C, 8'h0B);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_flags", int'({zero, carry, overflow, negative}), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(0, 8'h01, 8'h01);
    wait_idle();

    rnd_ready = 1;
    for (int i = 0; i < 150; i++) begin
      issue($urandom_range(0, 7), $urandom_range(0, MASK), $urandom_range(0, MASK));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rnd_ready = 0;
    repeat (2) @(negedge clk);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
